// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM data-memory controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arm_mem_pkg;

  // Controller phases: idle, low half-word, high half-word, one-cycle completion
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } mem_state_t;

  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
  localparam int          DEF_SRAM_AW   = 18;
  localparam int          DEF_WAIT_CYC  = 3;

  // Wide enough for WAIT_CYC up to 15
  localparam int          CNT_W         = 4;

endpackage

// File: rtl/sram_phase_cnt.sv
// Per-phase wait counter; flags the final cycle of a half-word phase.
// Latency: last is combinational from the registered count.
// Backpressure: none; clr has priority over inc.
module sram_phase_cnt
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  // Count cycles within a phase; restart at zero on clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(WAIT_CYC - 1));

endmodule

// File: rtl/sram_mem_ctrl.sv
// Maps 32-bit loads/stores onto a 16-bit async SRAM as two half-word phases.
// Latency: request cycle + 2*WAIT_CYC cycles low ready, ready high in DONE.
// Backpressure: ready=0 while an access is in flight freezes the pipeline.
module sram_mem_ctrl
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          SRAM_AW   = DEF_SRAM_AW,
  parameter int          WAIT_CYC  = DEF_WAIT_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read_en,
  input  logic               mem_write_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_we_n
);

  mem_state_t         state;
  mem_state_t         state_nxt;
  logic               req;
  logic               last;
  logic               cnt_inc;
  logic [31:0]        offset;
  logic [SRAM_AW-2:0] req_word;
  logic [SRAM_AW-2:0] lat_word;
  logic [31:0]        lat_wdata;
  logic               lat_wr;
  logic [15:0]        rd_lo;
  logic               unused_offset_bits;

  assign req = mem_read_en | mem_write_en;

  // Word index relative to the mapped base; out-of-range addresses wrap
  assign offset             = address - BASE_ADDR;
  assign req_word           = offset[SRAM_AW:2];
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  assign cnt_inc = (state == ST_LO) || (state == ST_HI);

  sram_phase_cnt #(
    .WAIT_CYC (WAIT_CYC)
  ) u_phase_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (~cnt_inc | last),
    .inc  (cnt_inc),
    .last (last)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: each half-word phase ends on the counter's terminal cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req)  state_nxt = ST_LO;
      ST_LO:   if (last) state_nxt = ST_HI;
      ST_HI:   if (last) state_nxt = ST_DONE;
      ST_DONE:           state_nxt = ST_IDLE;
      default:           state_nxt = ST_IDLE;
    endcase
  end

  // SRAM pins, request latch and read assembly change on phase-entry edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
      read_data  <= '0;
      rd_lo      <= '0;
      lat_word   <= '0;
      lat_wdata  <= '0;
      lat_wr     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            // A simultaneous read and write request is served as a write
            lat_word   <= req_word;
            lat_wdata  <= write_data;
            lat_wr     <= mem_write_en;
            sram_addr  <= {req_word, 1'b0};
            sram_we_n  <= ~mem_write_en;
            sram_dq_oe <= mem_write_en;
            if (mem_write_en) begin
              sram_dq_o <= write_data[15:0];
            end
          end
        end
        ST_LO: begin
          if (last) begin
            sram_addr <= {lat_word, 1'b1};
            if (lat_wr) begin
              sram_dq_o <= lat_wdata[31:16];
            end else begin
              rd_lo <= sram_dq_i;
            end
          end
        end
        ST_HI: begin
          if (last) begin
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!lat_wr) begin
              read_data <= {sram_dq_i, rd_lo};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ready = (state == ST_DONE) || ((state == ST_IDLE) && !req);

endmodule
